// File: rtl/tile_draw_scheduler_if.sv
`default_nettype none
// ============================================================================
// tile_draw_scheduler_if
// Request, sprite-ROM and VGA write-port bundle for tile_draw_scheduler.
// master: game-logic requesters plus ROM (the environment side).
// slave : the scheduler itself.
// Revision: 1.0 - initial release
// ============================================================================
interface tile_draw_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [4*N_REQ-1:0] req_gx;
   logic [4*N_REQ-1:0] req_gy;
   logic [2*N_REQ-1:0] req_sprite;
   logic [N_REQ-1:0]   grant;
   logic [N_REQ-1:0]   done;
   logic               done_err;
   logic               busy;
   logic [1:0]         rom_sprite;
   logic [8:0]         rom_addr;
   logic [8:0]         rom_q;
   logic [7:0]         vga_x;
   logic [6:0]         vga_y;
   logic [8:0]         vga_colour;
   logic               vga_plot;

   modport master (
      output req, req_gx, req_gy, req_sprite, rom_q,
      input  grant, done, done_err, busy, rom_sprite, rom_addr,
             vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  req, req_gx, req_gy, req_sprite, rom_q,
      output grant, done, done_err, busy, rom_sprite, rom_addr,
             vga_x, vga_y, vga_colour, vga_plot
   );
endinterface
`default_nettype wire

// File: rtl/tile_draw_scheduler.sv
`default_nettype none
// ============================================================================
// tile_draw_scheduler
// Round-robin arbiter that grants one 20x20 tile draw at a time, scans its
// 400 pixels through a synchronous sprite ROM and drives the VGA write port.
// Revision: 1.0 - initial release
// ============================================================================
module tile_draw_scheduler #(
   parameter int         N_REQ       = 4,
   parameter logic [8:0] TRANSPARENT = 9'h1FF
) (
   input  logic                 clk,
   input  logic                 reset,
   tile_draw_scheduler_if.slave bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DRAIN  = 3'd2,
      S_REJECT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
   logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
   logic               done_err_q, done_err_d;
   logic [3:0]         gx_q, gx_d, gy_q, gy_d;
   logic [1:0]         sprite_q, sprite_d;
   logic [4:0]         px_q, px_d, py_q, py_d;
   logic               drain_q, drain_d;
   logic               valid1_q, valid1_d;
   logic [4:0]         px1_q, px1_d, py1_q, py1_d;
   logic [7:0]         vga_x_q, vga_x_d;
   logic [6:0]         vga_y_q, vga_y_d;
   logic [8:0]         vga_colour_q, vga_colour_d;
   logic               vga_plot_q, vga_plot_d;

   logic [IDX_W-1:0]   next_ptr, arb_base, arb_cand, arb_idx;
   logic               arb_found, launch;
   logic [3:0]         gx_sel, gy_sel;
   logic [1:0]         sp_sel;

   // Pointer value that follows the requester currently being serviced.
   assign next_ptr = (int'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;

   // First pending requester at or above the base pointer, with wrap-around.
   // The DONE cycle arbitrates from the already-advanced pointer so a new
   // grant can appear in the very next cycle.
   always_comb begin
      arb_base  = (state_q == S_DONE) ? next_ptr : ptr_q;
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int o = 0; o < N_REQ; o++) begin
         arb_cand = IDX_W'((int'(arb_base) + o) % N_REQ);
         if (!arb_found && bus.req[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
      gx_sel = bus.req_gx[{arb_idx, 2'b00} +: 4];
      gy_sel = bus.req_gy[{arb_idx, 2'b00} +: 4];
      sp_sel = bus.req_sprite[{arb_idx, 1'b0} +: 2];
   end

   // Next-state logic: arbitration, pixel scan, drain, reject and done.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      grant_d    = grant_q;
      done_d     = '0;
      done_err_d = 1'b0;
      gx_d       = gx_q;
      gy_d       = gy_q;
      sprite_d   = sprite_q;
      px_d       = px_q;
      py_d       = py_q;
      drain_d    = drain_q;
      launch     = 1'b0;
      case (state_q)
         S_IDLE:  launch = arb_found;
         S_FETCH: begin
            if (px_q == 5'd19) begin
               px_d = 5'd0;
               if (py_q == 5'd19) begin
                  py_d    = 5'd0;
                  drain_d = 1'b0;
                  state_d = S_DRAIN;
               end else begin
                  py_d = py_q + 5'd1;
               end
            end else begin
               px_d = px_q + 5'd1;
            end
         end
         S_DRAIN: begin
            if (drain_q) begin
               state_d = S_DONE;
               grant_d = '0;
               done_d  = grant_q;
            end else begin
               drain_d = 1'b1;
            end
         end
         S_REJECT: begin
            state_d    = S_DONE;
            grant_d    = '0;
            done_d     = grant_q;
            done_err_d = 1'b1;
         end
         S_DONE: begin
            ptr_d   = next_ptr;
            state_d = S_IDLE;
            launch  = arb_found;
         end
         default: state_d = S_IDLE;
      endcase
      if (launch) begin
         idx_d          = arb_idx;
         grant_d        = '0;
         grant_d[arb_idx] = 1'b1;
         gx_d           = gx_sel;
         gy_d           = gy_sel;
         sprite_d       = sp_sel;
         px_d           = 5'd0;
         py_d           = 5'd0;
         state_d        = (gx_sel < 4'd8 && gy_sel < 4'd6) ? S_FETCH : S_REJECT;
      end
   end

   // Two-stage pixel pipeline: delay coordinates one cycle to meet rom_q.
   always_comb begin
      valid1_d     = (state_q == S_FETCH);
      px1_d        = px_q;
      py1_d        = py_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = valid1_q && (bus.rom_q != TRANSPARENT);
      if (valid1_q) begin
         vga_x_d      = {4'b0, gx_q} * 8'd20 + {3'b0, px1_q};
         vga_y_d      = {3'b0, gy_q} * 7'd20 + {2'b0, py1_q};
         vga_colour_d = bus.rom_q;
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         idx_q        <= '0;
         grant_q      <= '0;
         done_q       <= '0;
         done_err_q   <= 1'b0;
         gx_q         <= '0;
         gy_q         <= '0;
         sprite_q     <= '0;
         px_q         <= '0;
         py_q         <= '0;
         drain_q      <= 1'b0;
         valid1_q     <= 1'b0;
         px1_q        <= '0;
         py1_q        <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         done_err_q   <= done_err_d;
         gx_q         <= gx_d;
         gy_q         <= gy_d;
         sprite_q     <= sprite_d;
         px_q         <= px_d;
         py_q         <= py_d;
         drain_q      <= drain_d;
         valid1_q     <= valid1_d;
         px1_q        <= px1_d;
         py1_q        <= py1_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.done       = done_q;
   assign bus.done_err   = done_err_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.rom_sprite = sprite_q;
   assign bus.rom_addr   = (state_q == S_FETCH) ?
                           ({4'b0, py_q} * 9'd20 + {4'b0, px_q}) : 9'd0;
   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_colour = vga_colour_q;
   assign bus.vga_plot   = vga_plot_q;
endmodule
`default_nettype wire

// File: tb/tb_tile_draw_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tile_draw_scheduler
// Directed bench: reset, single draw, transparency, round robin, reject,
// reset mid-draw and corner tile, against hand-derived cycle expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tile_draw_scheduler;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   bit   transp_mode = 1'b0;

   always #5 clk = ~clk;

   tile_draw_scheduler_if #(.N_REQ(N)) bus ();

   tile_draw_scheduler #(.N_REQ(N), .TRANSPARENT(9'h1FF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous ROM: colour = address + sprite, or transparent on even px.
   always @(posedge clk) begin
      if (transp_mode && ((int'(bus.rom_addr) % 20) % 2 == 0))
         bus.rom_q <= 9'h1FF;
      else
         bus.rom_q <= bus.rom_addr + {7'b0, bus.rom_sprite};
   end

   task automatic set_fields(input int i, input logic [3:0] gx,
                             input logic [3:0] gy, input logic [1:0] sp);
      bus.req_gx[4*i +: 4]     = gx;
      bus.req_gy[4*i +: 4]     = gy;
      bus.req_sprite[2*i +: 2] = sp;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = '0;
      bus.req_gx = '0;
      bus.req_gy = '0;
      bus.req_sprite = '0;
      repeat (2) @(negedge clk);
      vectors++; if (bus.grant !== 4'b0) begin miscompares++; $display("FAIL reset_grant got=%b exp=0", bus.grant); end
      vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      vectors++; if (bus.done_err !== 1'b0) begin miscompares++; $display("FAIL reset_done_err got=%b exp=0", bus.done_err); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      vectors++; if (bus.rom_sprite !== 2'd0) begin miscompares++; $display("FAIL reset_rom_sprite got=%0d exp=0", bus.rom_sprite); end
      vectors++; if (bus.rom_addr !== 9'd0) begin miscompares++; $display("FAIL reset_rom_addr got=%0d exp=0", bus.rom_addr); end
      vectors++; if (bus.vga_x !== 8'd0) begin miscompares++; $display("FAIL reset_vga_x got=%0d exp=0", bus.vga_x); end
      vectors++; if (bus.vga_y !== 7'd0) begin miscompares++; $display("FAIL reset_vga_y got=%0d exp=0", bus.vga_y); end
      vectors++; if (bus.vga_colour !== 9'd0) begin miscompares++; $display("FAIL reset_vga_colour got=%0d exp=0", bus.vga_colour); end
      vectors++; if (bus.vga_plot !== 1'b0) begin miscompares++; $display("FAIL reset_vga_plot got=%b exp=0", bus.vga_plot); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int k;
      set_fields(0, 4'd2, 4'd1, 2'd0);
      bus.req = 4'b0001;
      for (int j = 1; j <= 403; j++) begin
         @(negedge clk);
         vectors++;
         if (bus.grant !== ((j <= 402) ? 4'b0001 : 4'b0000)) begin
            miscompares++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", j, bus.grant, (j <= 402) ? 4'b0001 : 4'b0000);
         end
         vectors++;
         if (bus.done !== ((j == 403) ? 4'b0001 : 4'b0000)) begin
            miscompares++; $display("FAIL single_done cyc=%0d got=%b", j, bus.done);
         end
         if (j <= 400) begin
            vectors++;
            if (bus.rom_addr !== 9'(j - 1)) begin
               miscompares++; $display("FAIL single_rom_addr cyc=%0d got=%0d exp=%0d", j, bus.rom_addr, j - 1);
            end
         end
         vectors++;
         if (bus.vga_plot !== (j >= 3 && j <= 402)) begin
            miscompares++; $display("FAIL single_plot cyc=%0d got=%b exp=%b", j, bus.vga_plot, (j >= 3 && j <= 402));
         end
         if (j >= 3 && j <= 402) begin
            k = j - 3;
            vectors++;
            if (bus.vga_x !== 8'(40 + k % 20) || bus.vga_y !== 7'(20 + k / 20) || bus.vga_colour !== 9'(k)) begin
               miscompares++;
               $display("FAIL single_pixel k=%0d got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                        k, bus.vga_x, bus.vga_y, bus.vga_colour, 40 + k % 20, 20 + k / 20, k);
            end
         end
         if (j == 1) bus.req = '0;
      end
      @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_transparency();
      int plots = 0;
      transp_mode = 1'b1;
      set_fields(0, 4'd0, 4'd0, 2'd0);
      bus.req = 4'b0001;
      for (int j = 1; j <= 403; j++) begin
         @(negedge clk);
         if (j == 1) bus.req = '0;
         if (bus.vga_plot === 1'b1) begin
            plots++;
            vectors++;
            if (bus.vga_x[0] !== 1'b1) begin
               miscompares++; $display("FAIL transp_odd_x got x=%0d exp odd", bus.vga_x);
            end
         end
         if (j == 403) begin
            vectors++;
            if (bus.done !== 4'b0001) begin miscompares++; $display("FAIL transp_done got=%b exp=0001", bus.done); end
         end
      end
      vectors++;
      if (plots != 200) begin miscompares++; $display("FAIL transp_count got=%0d exp=200", plots); end
      transp_mode = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int s, off;
      logic [3:0] oh;
      pulse_reset();
      for (int i = 0; i < N; i++) set_fields(i, 4'(i), 4'(i), 2'd0);
      bus.req = 4'b1111;
      for (int cyc = 1; cyc <= 403 * 5; cyc++) begin
         @(negedge clk);
         s   = (cyc - 1) / 403;
         off = (cyc - 1) % 403 + 1;
         oh  = 4'b0001 << (s % 4);
         if (off == 1) begin
            vectors++;
            if (bus.grant !== oh) begin miscompares++; $display("FAIL rr_grant svc=%0d got=%b exp=%b", s, bus.grant, oh); end
         end
         if (off == 403) begin
            vectors++;
            if (bus.done !== oh || bus.grant !== 4'b0) begin
               miscompares++; $display("FAIL rr_done svc=%0d got done=%b grant=%b exp done=%b grant=0000", s, bus.done, bus.grant, oh);
            end
         end
      end
      bus.req = '0;
      @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_out_of_range();
      set_fields(2, 4'd8, 4'd0, 2'd0);
      bus.req = 4'b0100;
      @(negedge clk);
      bus.req = '0;
      vectors++;
      if (bus.grant !== 4'b0100 || bus.done !== 4'b0 || bus.vga_plot !== 1'b0) begin
         miscompares++; $display("FAIL oor_grant got grant=%b done=%b plot=%b exp 0100/0000/0", bus.grant, bus.done, bus.vga_plot);
      end
      @(negedge clk);
      vectors++;
      if (bus.done !== 4'b0100 || bus.done_err !== 1'b1 || bus.grant !== 4'b0 || bus.vga_plot !== 1'b0) begin
         miscompares++; $display("FAIL oor_done got done=%b err=%b grant=%b plot=%b exp 0100/1/0000/0", bus.done, bus.done_err, bus.grant, bus.vga_plot);
      end
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.done_err !== 1'b0) begin
         miscompares++; $display("FAIL oor_idle got busy=%b err=%b exp 0/0", bus.busy, bus.done_err);
      end
   endtask

   task automatic test_reset_mid();
      set_fields(0, 4'd1, 4'd1, 2'd0);
      set_fields(3, 4'd0, 4'd0, 2'd0);
      bus.req = 4'b0001;
      for (int j = 1; j <= 151; j++) @(negedge clk);
      vectors++;
      if (bus.rom_addr !== 9'd150) begin miscompares++; $display("FAIL mid_addr got=%0d exp=150", bus.rom_addr); end
      reset = 1'b1;
      bus.req = '0;
      #1;
      vectors++;
      if (bus.grant !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.rom_addr !== 9'd0 ||
          bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0 || bus.vga_colour !== 9'd0 || bus.vga_plot !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset got grant=%b done=%b busy=%b addr=%0d x=%0d y=%0d c=%0d plot=%b exp all 0",
                  bus.grant, bus.done, bus.busy, bus.rom_addr, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.req = 4'b1001;
      for (int j = 1; j <= 403; j++) begin
         @(negedge clk);
         if (j == 1) begin
            bus.req = '0;
            vectors++;
            if (bus.grant !== 4'b0001 || bus.rom_addr !== 9'd0) begin
               miscompares++; $display("FAIL mid_regrant got grant=%b addr=%0d exp 0001/0", bus.grant, bus.rom_addr);
            end
         end
         if (j == 3) begin
            vectors++;
            if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'd20 || bus.vga_y !== 7'd20) begin
               miscompares++; $display("FAIL mid_first_pixel got plot=%b x=%0d y=%0d exp 1/20/20", bus.vga_plot, bus.vga_x, bus.vga_y);
            end
         end
         if (j == 403) begin
            vectors++;
            if (bus.done !== 4'b0001) begin miscompares++; $display("FAIL mid_done got=%b exp=0001", bus.done); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_corner();
      logic [7:0] last_x = '0;
      logic [6:0] last_y = '0;
      logic [8:0] last_c = '0;
      set_fields(1, 4'd7, 4'd5, 2'd2);
      bus.req = 4'b0010;
      for (int j = 1; j <= 403; j++) begin
         @(negedge clk);
         if (j == 1) begin
            bus.req = '0;
            vectors++;
            if (bus.grant !== 4'b0010 || bus.rom_sprite !== 2'd2) begin
               miscompares++; $display("FAIL corner_grant got grant=%b sprite=%0d exp 0010/2", bus.grant, bus.rom_sprite);
            end
         end
         vectors++;
         if (bus.rom_addr > 9'd399) begin miscompares++; $display("FAIL corner_addr cyc=%0d got=%0d exp<=399", j, bus.rom_addr); end
         if (bus.vga_plot === 1'b1) begin
            last_x = bus.vga_x;
            last_y = bus.vga_y;
            last_c = bus.vga_colour;
         end
         if (j == 403) begin
            vectors++;
            if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL corner_done got=%b exp=0010", bus.done); end
         end
      end
      vectors++;
      if (last_x !== 8'd159 || last_y !== 7'd119 || last_c !== 9'd401) begin
         miscompares++; $display("FAIL corner_last got x=%0d y=%0d c=%0d exp 159/119/401", last_x, last_y, last_c);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_transparency();
      test_round_robin();
      test_out_of_range();
      test_reset_mid();
      test_corner();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tile_draw_scheduler.md
# tile_draw_scheduler

Round-robin scheduler that shares one sprite ROM port and the VGA write port among several tile-drawing requesters (tower, car, background, cursor). Each requester asks for one 20x20 tile to be drawn at a grid cell; the scheduler grants one request at a time, scans the 400 pixels, absorbs the synchronous-ROM read latency and drives the VGA adapter's x/y/colour/plot inputs. It sits between the game-logic FSMs and the VGA adapter on the 160x120 screen, an 8x6 grid of 20x20 tiles.

## Interface
- N_REQ, 4: number of requesters (2..8).
- TRANSPARENT, 9'h1FF: ROM colour value that is never plotted.
- clk  in  1  system clock; every register samples on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  N_REQ  per-requester draw request (level).
- req_gx  in  4*N_REQ  grid column per requester, slice i = [4i+3:4i]; valid range 0..7.
- req_gy  in  4*N_REQ  grid row per requester; valid range 0..5.
- req_sprite  in  2*N_REQ  sprite select per requester.
- grant  out  N_REQ  one-hot; high for the whole service of that requester.
- done  out  N_REQ  one-cycle pulse at the end of service.
- done_err  out  1  pulses with done when the tile was rejected as out of range.
- busy  out  1  high in any state other than IDLE.
- rom_sprite  out  2  sprite select to the ROM bank.
- rom_addr  out  9  pixel address, py*20+px.
- rom_q  in  9  ROM data, valid one cycle after rom_addr is sampled.
- vga_x  out  8,  vga_y  out  7,  vga_colour  out  9,  vga_plot  out  1: VGA adapter write port.

## Operation
- States: IDLE, FETCH, DRAIN, REJECT, DONE.
- IDLE: if any req bit is high, pick the first set bit searching upward from the pointer `ptr`, wrapping modulo N_REQ. Latch gx, gy and sprite for that bit. Register the one-hot grant.
  - If gx<8 and gy<6, go to FETCH with px=py=0.
  - Otherwise go to REJECT.
- FETCH: drive rom_addr = py*20+px and rom_sprite = the latched sprite.
  - Each cycle px increments. At px=19, px wraps to 0 and py increments.
  - After pixel (19,19) is issued, go to DRAIN.
- Pipeline: rom_q arrives one cycle after the address. On that cycle the outputs are registered:
  - vga_x = gx*20+px_d and vga_y = gy*20+py_d, using the delayed pixel coordinates.
  - vga_colour = rom_q.
  - vga_plot = 1, unless rom_q == TRANSPARENT.
- DRAIN: lasts 2 cycles, to flush the pipeline. vga_plot is 0 after the last pixel.
- DONE: lasts one cycle. done[i] = 1, grant drops to 0, ptr = (i+1) mod N_REQ, then return to IDLE.
- REJECT: lasts one cycle, with no ROM or VGA activity. Then DONE with done_err = 1.
- Widths: gx*20+px has a maximum of 159, which fits in 8 bits. gy*20+py has a maximum of 119, which fits in 7 bits. rom_addr has a maximum of 399. No truncation occurs in the valid range.
- Request fields are sampled only at grant. Changes or deassertion of req during service are ignored and do not abort the draw.
- A requester still holding req after its done is eligible again, but ptr has moved past it, so other pending requesters win first.
- Simultaneous requests: exactly one is granted per arbitration, chosen by the rotating pointer. There is no starvation: every pending requester is served within N_REQ services.
- Reset mid-draw: the asynchronous return to IDLE drops grant with no done pulse, and ptr returns to 0. The requester must re-request.

## Timing
- Reset values: grant=0, done=0, done_err=0, busy=0, rom_sprite=0, rom_addr=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, ptr=0, state=IDLE.
- Let cycle c be an IDLE cycle in which req is sampled high.
  - Cycles c+1..c+400 (FETCH): grant and busy are high, and pixel k's address appears in cycle c+1+k.
  - Cycles c+3..c+402: vga_plot may be high for pixel k in cycle c+3+k, giving 2-cycle address-to-plot latency.
  - Cycles c+401..c+402: DRAIN.
  - Cycle c+403: DONE, with done high and grant low.
  - Cycle c+404: the earliest new grant.
- Total cost: 403 cycles per tile, exclusive of the arbitration cycle. Throughput is 1 pixel/cycle.
- Rejected tile: grant is high in c+1, then done and done_err are high in c+2.

## Test plan
- Single request: req[0]=1, gx=2, gy=1. Expect grant[0] in cycles c+1..c+402; 400 plots covering x 40..59 and y 20..39 in row-major order; done[0] in c+403.
- Transparency: the ROM returns 9'h1FF for even px. Expect exactly 200 plots, all at odd x offsets.
- Round robin: req=4'b1111 held continuously. Expect the grant order 0,1,2,3,0. Each done is followed one cycle later by the next grant.
- Out of range: gx=8 on requester 2. Expect grant[2] for one cycle, then done[2] and done_err together, with no vga_plot.
- Reset mid-draw: assert reset at pixel 150. Immediately all outputs are 0 with no done; after release and re-request, the draw restarts from pixel (0,0) with grant[0].
- Corner tile: gx=7, gy=5. Expect the last plot at x=159, y=119; rom_addr never exceeds 399.
